// File: rtl/multi_vc_wrf_channel.sv
// Multi-VC write channel: per-VC in-FIFOs, round-robin arbitration into a shared out-FIFO,
// write fences act as global barriers. Define MULTI_VC_WRF_FENCE_FWD_EN to forward retired fences.

module multi_vc_wrf_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_BASE2 = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [DEPTH_BASE2:0]   cnt
);
    localparam logic [DEPTH_BASE2:0] DEPTH = {1'b1, {DEPTH_BASE2{1'b0}}};

    logic [WIDTH-1:0]       mem [0:(1<<DEPTH_BASE2)-1];
    logic [DEPTH_BASE2-1:0] wr_ptr;
    logic [DEPTH_BASE2-1:0] rd_ptr;
    logic                   wr_ok;
    logic                   rd_ok;

    // A push into a completely full FIFO is dropped even if a pop happens in the same cycle.
    assign wr_ok = push && (cnt != DEPTH);
    assign rd_ok = pop && (cnt != '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (DEPTH_BASE2+1)'(wr_ok) - (DEPTH_BASE2+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module multi_vc_wrf_channel #(
    parameter int                    NUM_VC          = 4,
    parameter int                    HDR_WIDTH       = 61,
    parameter int                    DATA_WIDTH      = 512,
    parameter int                    TYPE_LSB        = 4,
    parameter int                    TYPE_WIDTH      = 4,
    parameter logic [TYPE_WIDTH-1:0] WRFENCE_CODE    = 4'h4,
    parameter int                    IN_DEPTH_BASE2  = 7,
    parameter int                    IN_FULL_THRESH  = 96,
    parameter int                    OUT_DEPTH_BASE2 = 3,
    parameter int                    OUT_FULL_THRESH = 5,
    parameter int                    VC_W            = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_VC-1:0]            write_en,
    input  logic [NUM_VC*HDR_WIDTH-1:0]  meta_in,
    input  logic [NUM_VC*DATA_WIDTH-1:0] data_in,
    output logic [NUM_VC-1:0]            full,
    input  logic                         read_en,
    output logic [HDR_WIDTH-1:0]         meta_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [VC_W-1:0]              vc_out,
    output logic [31:0]                  tid_out,
    output logic                         valid_out,
    output logic                         empty,
    output logic                         fence_active,
    output logic                         overflow,
    output logic                         underflow,
    output logic [31:0]                  count
);
    localparam int IN_W  = 32 + HDR_WIDTH + DATA_WIDTH;   // {tid, meta, data}
    localparam int OUT_W = VC_W + IN_W;                   // {vc, tid, meta, data}
    localparam logic [IN_DEPTH_BASE2:0]  IN_DEPTH = {1'b1, {IN_DEPTH_BASE2{1'b0}}};
    localparam logic [IN_DEPTH_BASE2:0]  IN_THR   = (IN_DEPTH_BASE2+1)'(IN_FULL_THRESH);
    localparam logic [OUT_DEPTH_BASE2:0] OUT_DEPTH = {1'b1, {OUT_DEPTH_BASE2{1'b0}}};
    localparam logic [OUT_DEPTH_BASE2:0] OUT_THR   = (OUT_DEPTH_BASE2+1)'(OUT_FULL_THRESH);

    typedef enum logic [1:0] {IDLE, DRAIN, RELEASE} fsm_t;

    fsm_t state, state_nxt;

    logic [NUM_VC-1:0][31:0]               tid_q;
    logic [NUM_VC-1:0][IN_W-1:0]           in_head;
    logic [NUM_VC-1:0][IN_DEPTH_BASE2:0]   in_cnt;
    logic [NUM_VC-1:0]                     in_vld;
    logic [NUM_VC-1:0]                     in_pop;
    logic [NUM_VC-1:0]                     in_ovf;
    logic [NUM_VC-1:0]                     head_fence;
    logic [NUM_VC-1:0]                     eligible;
    logic [NUM_VC-1:0]                     rel_pop;
    logic [NUM_VC-1:0][VC_W-1:0]           cand;

    logic [VC_W-1:0]  rr_ptr;
    logic             gnt_vld;
    logic [VC_W-1:0]  gnt_idx;

    logic             stg_vld;
    logic [OUT_W-1:0] stg_q;
    logic [OUT_W-1:0] stg_d;
    logic             stg_load;
    logic             stg_free;

    logic [OUT_W-1:0]           out_head;
    logic [OUT_DEPTH_BASE2:0]   out_cnt;
    logic                       out_wr;
    logic                       out_pop;
    logic                       out_afull;

`ifdef MULTI_VC_WRF_FENCE_FWD_EN
    logic             fwd_vld;
    logic [VC_W-1:0]  fwd_idx;
`endif

    // ---------------- per-VC input side ----------------
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        multi_vc_wrf_fifo #(.WIDTH(IN_W), .DEPTH_BASE2(IN_DEPTH_BASE2)) u_in (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (write_en[v]),
            .pop   (in_pop[v]),
            .wdata ({tid_q[v], meta_in[v*HDR_WIDTH +: HDR_WIDTH], data_in[v*DATA_WIDTH +: DATA_WIDTH]}),
            .head  (in_head[v]),
            .cnt   (in_cnt[v])
        );

        assign in_vld[v]     = (in_cnt[v] != '0);
        assign head_fence[v] = in_vld[v] &&
                               (in_head[v][DATA_WIDTH+TYPE_LSB +: TYPE_WIDTH] == WRFENCE_CODE);
        assign full[v]       = (in_cnt[v] >= IN_THR);
        assign in_ovf[v]     = write_en[v] && (in_cnt[v] == IN_DEPTH);
        assign eligible[v]   = in_vld[v] && !head_fence[v] && (state == IDLE) &&
                               !out_afull && stg_free;
        assign in_pop[v]     = (gnt_vld && (gnt_idx == VC_W'(v))) || rel_pop[v];
    end

    // Every write_en consumes a tid, including fences and dropped writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (write_en[v]) tid_q[v] <= tid_q[v] + 32'd1;
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    // rr_ptr holds the first VC to search, i.e. the one after the last grant.
    always_comb begin
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand[i] = VC_W'((int'(rr_ptr) + i) % NUM_VC);
            if (!gnt_vld && eligible[cand[i]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_idx == VC_W'(NUM_VC-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---------------- fence FSM ----------------
    always_comb begin
        state_nxt = state;
        rel_pop   = '0;
`ifdef MULTI_VC_WRF_FENCE_FWD_EN
        fwd_vld   = 1'b0;
        fwd_idx   = '0;
`endif
        case (state)
            IDLE:    if (|head_fence) state_nxt = DRAIN;
            DRAIN:   if (!stg_vld && (out_cnt == '0)) state_nxt = RELEASE;
            RELEASE: begin
`ifdef MULTI_VC_WRF_FENCE_FWD_EN
                // One fence per cycle through staging, lowest VC first.
                for (int i = NUM_VC-1; i >= 0; i--) begin
                    if (head_fence[i]) fwd_idx = VC_W'(i);
                end
                fwd_vld = (|head_fence) && stg_free;
                if (fwd_vld) rel_pop[fwd_idx] = 1'b1;
                if ((fwd_vld && ((head_fence & (head_fence - 1'b1)) != '0)) ||
                    (!fwd_vld && (|head_fence)))
                    state_nxt = RELEASE;
                else
                    state_nxt = IDLE;
`else
                rel_pop   = head_fence;
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign fence_active = (state != IDLE);

    // ---------------- staging register ----------------
    always_comb begin
        stg_load = gnt_vld;
        stg_d    = {gnt_idx, in_head[gnt_idx]};
`ifdef MULTI_VC_WRF_FENCE_FWD_EN
        if (fwd_vld) begin
            stg_load = 1'b1;
            stg_d    = {fwd_idx, in_head[fwd_idx][IN_W-1:DATA_WIDTH], {DATA_WIDTH{1'b0}}};
        end
`endif
    end

    assign out_wr   = stg_vld && (out_cnt != OUT_DEPTH);
    assign stg_free = !stg_vld || out_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= 1'b0;
            stg_q   <= '0;
        end else if (stg_load) begin
            stg_vld <= 1'b1;
            stg_q   <= stg_d;
        end else if (out_wr) begin
            stg_vld <= 1'b0;
        end
    end

    // ---------------- output side ----------------
    // Grants continue while the out-FIFO holds at most OUT_FULL_THRESH entries;
    // with the staging slot in flight it tops out at OUT_FULL_THRESH+2.
    assign out_afull = (out_cnt > OUT_THR);
    assign out_pop   = read_en && (out_cnt != '0);
    assign empty     = (out_cnt == '0);

    multi_vc_wrf_fifo #(.WIDTH(OUT_W), .DEPTH_BASE2(OUT_DEPTH_BASE2)) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (out_wr),
        .pop   (out_pop),
        .wdata (stg_q),
        .head  (out_head),
        .cnt   (out_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            meta_out  <= '0;
            data_out  <= '0;
            vc_out    <= '0;
            tid_out   <= '0;
        end else begin
            valid_out <= out_pop;
            if (out_pop) {vc_out, tid_out, meta_out, data_out} <= out_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (|in_ovf);
            underflow <= underflow | (read_en && (out_cnt == '0));
        end
    end

    always_comb begin
        count = 32'(stg_vld) + 32'(out_cnt);
        for (int v = 0; v < NUM_VC; v++) count = count + 32'(in_cnt[v]);
    end
endmodule
